// File: rtl/axi_duth_mon_pkg.sv
// Shared definitions for the AXI read-channel monitor: error bit indices,
// burst encodings and the WRAP length legality helper.
package axi_duth_mon_pkg;

    typedef enum logic [2:0] {
        AR_UNSTABLE  = 3'd0,
        R_UNSTABLE   = 3'd1,
        ORPHAN_R     = 3'd2,
        LAST_EARLY   = 3'd3,
        LAST_MISSING = 3'd4,
        OVERFLOW     = 3'd5,
        BAD_BURST    = 3'd6
    } err_idx_e;

    localparam int ERR_W = 7;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RES   = 2'b11;

    // WRAP bursts must be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_legal(input int unsigned len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

endpackage

// File: rtl/axi_duth_len_fifo.sv
// Pointer-based FIFO holding the ARLEN of each outstanding burst for one ID.
// Head is presented combinationally so the monitor can check the current R beat.
module axi_duth_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axi_duth_r_monitor.sv
// Passive AXI read-channel protocol monitor: per-ID burst tracking, RLAST checks,
// handshake stability and burst legality. Define AXI_R_MONITOR_FATAL_EN to stop simulation on any new error.
module axi_duth_r_monitor
    import axi_duth_mon_pkg::*;
#(
    parameter int AXI_MODE        = 4,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int SIZE_WIDTH      = 3,
    parameter int AR_TID_WIDTH    = 1,
    parameter int R_DATA_WIDTH    = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                clear_err,
    input  logic                                                ar_valid,
    input  logic                                                ar_ready,
    input  logic [AR_TID_WIDTH-1:0]                             ar_tid,
    input  logic [ADDRESS_WIDTH-1:0]                            ar_addr,
    input  logic [LEN_WIDTH-1:0]                                ar_len,
    input  logic [SIZE_WIDTH-1:0]                               ar_size,
    input  logic [1:0]                                          ar_burst,
    input  logic                                                r_valid,
    input  logic                                                r_ready,
    input  logic [AR_TID_WIDTH-1:0]                             r_tid,
    input  logic [R_DATA_WIDTH-1:0]                             r_data,
    input  logic [1:0]                                          r_resp,
    input  logic                                                r_last,
    output logic [ERR_W-1:0]                                    err_flags,
    output logic                                                err_pulse,
    output logic [AR_TID_WIDTH+$clog2(MAX_OUTSTANDING):0]       outstanding,
    output logic [CNT_WIDTH-1:0]                                bursts_done,
    output logic                                                idle
);

    localparam int NUM_IDS  = 2 ** AR_TID_WIDTH;
    localparam int OUT_W    = AR_TID_WIDTH + $clog2(MAX_OUTSTANDING) + 1;
    localparam int MAX_SIZE = $clog2(R_DATA_WIDTH / 8);
    localparam int AR_PW    = AR_TID_WIDTH + ADDRESS_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;
    localparam int R_PW     = AR_TID_WIDTH + R_DATA_WIDTH + 3;

`ifdef AXI_R_MONITOR_FATAL_EN
    localparam bit FATAL_EN = 1'b1;
`else
    localparam bit FATAL_EN = 1'b0;
`endif

    logic                 ar_hs;
    logic                 r_hs;
    logic [AR_PW-1:0]     ar_payload;
    logic [R_PW-1:0]      r_payload;

    logic                 ar_stall_q;
    logic [AR_PW-1:0]     ar_payload_q;
    logic                 r_stall_q;
    logic [R_PW-1:0]      r_payload_q;

    logic [NUM_IDS-1:0]   push_w;
    logic [NUM_IDS-1:0]   pop_w;
    logic [NUM_IDS-1:0]   full_w;
    logic [NUM_IDS-1:0]   empty_w;
    logic [LEN_WIDTH-1:0] head_w [NUM_IDS];

    logic [LEN_WIDTH-1:0] cnt_q [NUM_IDS];
    logic [LEN_WIDTH-1:0] cnt_d [NUM_IDS];
    logic                 busy_d;

    logic                 r_empty;
    logic [LEN_WIDTH-1:0] r_head;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_match;
    logic                 at_len;
    logic                 burst_end;
    logic                 clean_end;

    logic [ADDRESS_WIDTH-1:0] align_mask;
    logic                 bad_burst;
    logic [ERR_W-1:0]     new_err;

    logic [ERR_W-1:0]     err_flags_q;
    logic [ERR_W-1:0]     err_flags_d;
    logic                 err_pulse_q;
    logic [OUT_W-1:0]     outstanding_q;
    logic [OUT_W-1:0]     outstanding_d;
    logic [CNT_WIDTH-1:0] bursts_done_q;
    logic [CNT_WIDTH-1:0] bursts_done_d;
    logic                 idle_q;
    logic                 idle_d;

    assign ar_hs      = ar_valid && ar_ready;
    assign r_hs       = r_valid && r_ready;
    assign ar_payload = {ar_tid, ar_addr, ar_len, ar_size, ar_burst};
    assign r_payload  = {r_tid, r_data, r_resp, r_last};

    // A stalled transfer must hold valid and payload until the cycle it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_stall_q   <= 1'b0;
            ar_payload_q <= '0;
            r_stall_q    <= 1'b0;
            r_payload_q  <= '0;
        end else begin
            ar_stall_q   <= ar_valid && !ar_ready;
            ar_payload_q <= ar_payload;
            r_stall_q    <= r_valid && !r_ready;
            r_payload_q  <= r_payload;
        end
    end

    assign align_mask = ~({ADDRESS_WIDTH{1'b1}} << ar_size);

    always_comb begin
        bad_burst = 1'b0;
        if (ar_valid) begin
            if (ar_burst == BURST_RES) begin
                bad_burst = 1'b1;
            end
            if (ar_size > SIZE_WIDTH'(MAX_SIZE)) begin
                bad_burst = 1'b1;
            end
            if ((ar_burst == BURST_WRAP) &&
                (!wrap_len_legal(32'(ar_len)) || ((ar_addr & align_mask) != '0))) begin
                bad_burst = 1'b1;
            end
            if ((AXI_MODE == 3) && (ar_len > LEN_WIDTH'(15))) begin
                bad_burst = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_id
        assign push_w[gi] = ar_hs && (ar_tid == AR_TID_WIDTH'(gi)) && !full_w[gi];
        assign pop_w[gi]  = burst_end && (r_tid == AR_TID_WIDTH'(gi));

        axi_duth_len_fifo #(
            .DEPTH (MAX_OUTSTANDING),
            .WIDTH (LEN_WIDTH)
        ) u_len_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_w[gi]),
            .pop   (pop_w[gi]),
            .din   (ar_len),
            .head  (head_w[gi]),
            .full  (full_w[gi]),
            .empty (empty_w[gi])
        );
    end

    // R beats are judged against queue state before this edge, so a same-cycle AR never matches.
    assign r_empty   = empty_w[r_tid];
    assign r_head    = head_w[r_tid];
    assign r_cnt     = cnt_q[r_tid];
    assign r_match   = r_hs && !r_empty;
    assign at_len    = (r_cnt == r_head);
    assign burst_end = r_match && (r_last || at_len);
    assign clean_end = r_match && r_last && at_len;

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (r_match && (r_tid == AR_TID_WIDTH'(i))) begin
                cnt_d[i] = burst_end ? '0 : cnt_q[i] + LEN_WIDTH'(1);
            end
            busy_d = busy_d || (cnt_d[i] != '0);
        end
    end

    always_comb begin
        new_err               = '0;
        new_err[AR_UNSTABLE]  = ar_stall_q && (!ar_valid || (ar_payload != ar_payload_q));
        new_err[R_UNSTABLE]   = r_stall_q && (!r_valid || (r_payload != r_payload_q));
        new_err[ORPHAN_R]     = r_hs && r_empty;
        new_err[LAST_EARLY]   = r_match && r_last && !at_len;
        new_err[LAST_MISSING] = r_match && !r_last && at_len;
        new_err[OVERFLOW]     = ar_hs && full_w[ar_tid];
        new_err[BAD_BURST]    = bad_burst;
    end

    assign err_flags_d   = (clear_err ? '0 : err_flags_q) | new_err;
    assign outstanding_d = outstanding_q + OUT_W'(|push_w) - OUT_W'(|pop_w);
    assign bursts_done_d = bursts_done_q + (clean_end ? CNT_WIDTH'(1) : '0);
    assign idle_d        = (outstanding_d == '0) && !busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags_q   <= '0;
            err_pulse_q   <= 1'b0;
            outstanding_q <= '0;
            bursts_done_q <= '0;
            idle_q        <= 1'b1;
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_flags_q   <= err_flags_d;
            err_pulse_q   <= |new_err;
            outstanding_q <= outstanding_d;
            bursts_done_q <= bursts_done_d;
            idle_q        <= idle_d;
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign err_flags   = err_flags_q;
    assign err_pulse   = err_pulse_q;
    assign outstanding = outstanding_q;
    assign bursts_done = bursts_done_q;
    assign idle        = idle_q;

    if (FATAL_EN) begin : g_fatal
        err_idx_e first_err;

        always_comb begin
            first_err = AR_UNSTABLE;
            for (int i = ERR_W - 1; i >= 0; i--) begin
                if (new_err[i]) begin
                    first_err = err_idx_e'(i);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst && (new_err != '0)) begin
                $fatal(1, "axi_duth_r_monitor: %s ar_tid=%0d r_tid=%0d beat_cnt=%0d",
                       first_err.name(), ar_tid, r_tid, r_cnt);
            end
        end
    end

endmodule
